// File: rtl/hanoi_pkg.sv
// Shared types and helpers for the Towers of Hanoi move generator.
// Peg codes, FSM encoding and the modulo-3 reduction used by the move formula.
package hanoi_pkg;

    typedef logic [1:0] peg_t;

    localparam peg_t PEG0 = 2'd0;
    localparam peg_t PEG1 = 2'd1;
    localparam peg_t PEG2 = 2'd2;

    // Largest supported disk count; move formula operands are MAX_N+1 bits wide.
    localparam int MAX_N = 15;
    localparam int OPW   = MAX_N + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Remainder folding MSB first: r' = (2r + bit) mod 3 keeps r in 0..2.
    function automatic peg_t mod3(input logic [OPW-1:0] x);
        logic [2:0] t;
        logic [1:0] r;
        r = 2'd0;
        for (int i = OPW - 1; i >= 0; i--) begin
            t = {r, 1'b0} + {2'b00, x[i]};
            if (t >= 3'd3) begin
                t = t - 3'd3;
            end
            r = t[1:0];
        end
        return r;
    endfunction

    function automatic peg_t swap12(input peg_t p);
        peg_t q;
        q = p;
        if (p == PEG1) begin
            q = PEG2;
        end else if (p == PEG2) begin
            q = PEG1;
        end
        return q;
    endfunction

endpackage

// File: rtl/hanoi_peg_tracker.sv
// Shadow model of disk positions: three bitmaps (bit i = disk i, disk 0 smallest)
// with a combinational legality check of the move presented on fr/to.
module hanoi_peg_tracker
    import hanoi_pkg::*;
#(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic init,
    input  logic apply,
    input  peg_t fr,
    input  peg_t to,
    output logic illegal
);

    logic [N-1:0] peg_q [3];
    logic [N-1:0] peg_d [3];
    logic [N-1:0] src_bits;
    logic [N-1:0] dst_bits;
    logic [N-1:0] mask;
    logic [3:0]   src_top;
    logic [3:0]   dst_top;

    // Priority encoder: the top disk of a peg is its lowest set bit.
    function automatic logic [3:0] top_of(input logic [N-1:0] b);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (b[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    always_comb begin
        src_bits = '0;
        dst_bits = '0;
        for (int p = 0; p < 3; p++) begin
            if (fr == peg_t'(p)) begin
                src_bits = peg_q[p];
            end
            if (to == peg_t'(p)) begin
                dst_bits = peg_q[p];
            end
        end
        src_top = top_of(src_bits);
        dst_top = top_of(dst_bits);
        illegal = (src_bits == '0) || ((dst_bits != '0) && (dst_top <= src_top));
    end

    // An illegal move is still committed so the shadow follows what the consumer saw.
    always_comb begin
        mask = '0;
        if (src_bits != '0) begin
            mask = N'(1) << src_top;
        end
        for (int p = 0; p < 3; p++) begin
            peg_d[p] = peg_q[p];
            if (apply) begin
                if (fr == peg_t'(p)) begin
                    peg_d[p] = peg_d[p] & ~mask;
                end
                if (to == peg_t'(p)) begin
                    peg_d[p] = peg_d[p] | mask;
                end
            end
        end
        if (init) begin
            peg_d[0] = '1;
            peg_d[1] = '0;
            peg_d[2] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peg_q[0] <= '1;
            peg_q[1] <= '0;
            peg_q[2] <= '0;
        end else begin
            for (int p = 0; p < 3; p++) begin
                peg_q[p] <= peg_d[p];
            end
        end
    end

endmodule

// File: rtl/hanoi_solver.sv
// Emits the optimal 2^N-1 move sequence taking N disks from peg 0 to peg 2,
// one move per accepted handshake, while a peg tracker flags illegal moves.
module hanoi_solver
    import hanoi_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = N
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          mv_valid,
    input  logic          mv_ready,
    output logic [1:0]    mv_fr,
    output logic [1:0]    mv_to,
    output logic [IW-1:0] mv_idx,
    output logic          busy,
    output logic          done,
    output logic          err,
    output state_t        dbg_state
);

    localparam int             MW     = N + 1;
    localparam logic [MW-1:0]  ONE    = MW'(1);
    localparam logic [MW-1:0]  LAST   = MW'((2 ** N) - 1);
    localparam bit             EVEN_N = (N % 2) == 0;

    state_t        state_q, state_d;
    logic [MW-1:0] m_q, m_d;
    peg_t          fr_q, fr_d;
    peg_t          to_q, to_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          err_q, err_d;
    logic          load;
    logic          hs;
    logic          trk_init;
    logic          trk_apply;
    logic          trk_illegal;

    // Odd-N formula lands on peg 2; for even N relabelling pegs 1/2 does the same.
    function automatic peg_t src_of(input logic [MW-1:0] m);
        logic [MW-1:0] a;
        peg_t          p;
        a = m & (m - ONE);
        p = mod3(OPW'(a));
        return EVEN_N ? swap12(p) : p;
    endfunction

    // N+1 bits keep (m | (m-1)) + 1 = 2^N from wrapping on the last move.
    function automatic peg_t dst_of(input logic [MW-1:0] m);
        logic [MW-1:0] b;
        peg_t          p;
        b = (m | (m - ONE)) + ONE;
        p = mod3(OPW'(b));
        return EVEN_N ? swap12(p) : p;
    endfunction

    // Valid/ready: a move transfers in any cycle where mv_valid & mv_ready; while
    // mv_valid is high and mv_ready low the presented move holds unchanged.
    assign mv_valid = (state_q == ST_RUN);
    assign hs       = mv_valid & mv_ready;

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        fr_d      = fr_q;
        to_d      = to_q;
        idx_d     = idx_q;
        err_d     = err_q;
        load      = 1'b0;
        trk_init  = 1'b0;
        trk_apply = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    m_d      = ONE;
                    err_d    = 1'b0;
                    trk_init = 1'b1;
                    load     = 1'b1;
                end
            end
            ST_RUN: begin
                if (hs) begin
                    trk_apply = 1'b1;
                    err_d     = err_q | trk_illegal;
                    if (m_q == LAST) begin
                        state_d = ST_DONE;
                        fr_d    = PEG0;
                        to_d    = PEG0;
                        idx_d   = '0;
                    end else begin
                        m_d  = m_q + ONE;
                        load = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                fr_d    = PEG0;
                to_d    = PEG0;
                idx_d   = '0;
            end
        endcase
        if (load) begin
            fr_d  = src_of(m_d);
            to_d  = dst_of(m_d);
            idx_d = IW'(m_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            fr_q    <= PEG0;
            to_q    <= PEG0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            fr_q    <= fr_d;
            to_q    <= to_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    hanoi_peg_tracker #(
        .N(N)
    ) u_trk (
        .clk    (clk),
        .rst    (rst),
        .init   (trk_init),
        .apply  (trk_apply),
        .fr     (fr_q),
        .to     (to_q),
        .illegal(trk_illegal)
    );

    assign mv_fr     = fr_q;
    assign mv_to     = to_q;
    assign mv_idx    = idx_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule
